// File: rtl/memory_flash_arbiter.sv
// Round-robin arbiter sharing the flash read port between port A (CPU/boot) and port B (PI).
// Optional watchdog on the outstanding read: define FLASH_ARB_TIMEOUT_EN.
module memory_flash_arbiter #(
    parameter int unsigned ADDR_W         = 19,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic              i_clk,
    input  logic              i_reset_n,

    input  logic              i_a_request,
    output logic              o_a_busy,
    input  logic [ADDR_W-1:0] i_a_address,
    output logic              o_a_ack,
    output logic [DATA_W-1:0] o_a_data,

    input  logic              i_b_request,
    output logic              o_b_busy,
    input  logic [ADDR_W-1:0] i_b_address,
    output logic              o_b_ack,
    output logic [DATA_W-1:0] o_b_data,

    output logic              o_flash_request,
    input  logic              i_flash_busy,
    output logic [ADDR_W-1:0] o_flash_address,
    input  logic              i_flash_ack,
    input  logic [DATA_W-1:0] i_flash_data,

    output logic              o_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK
    } state_t;

    state_t              state_q, state_d;
    logic                last_b_q, last_b_d;
    logic                owner_b_q, owner_b_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                a_ack_q, a_ack_d;
    logic                b_ack_q, b_ack_d;
    logic [DATA_W-1:0]   a_data_q, a_data_d;
    logic [DATA_W-1:0]   b_data_q, b_data_d;

    logic                grant_a;
    logic                grant_b;
    logic                expire;
    logic                done;
    logic [DATA_W-1:0]   done_data;

    // Tie goes to the port that did not win last time.
    always_comb begin
        grant_a = i_a_request && (!i_b_request || last_b_q);
        grant_b = i_b_request && (!i_a_request || !last_b_q);
    end

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        expire    = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        cnt_d     = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
        timeout_d = timeout_q || (done && done_data == '1 && expire && !(state_q == WAIT_ACK && i_flash_ack));
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign expire    = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            last_b_q  <= 1'b1;
            owner_b_q <= 1'b0;
            addr_q    <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_data_q  <= '0;
            b_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            owner_b_q <= owner_b_d;
            addr_q    <= addr_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_b_d  = last_b_q;
        owner_b_d = owner_b_q;
        addr_d    = addr_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_data_d  = a_data_q;
        b_data_d  = b_data_q;
        done      = 1'b0;
        done_data = '1;

        case (state_q)
            IDLE: begin
                if (grant_a) begin
                    addr_d    = i_a_address;
                    owner_b_d = 1'b0;
                    last_b_d  = 1'b0;
                    state_d   = ISSUE;
                end else if (grant_b) begin
                    addr_d    = i_b_address;
                    owner_b_d = 1'b1;
                    last_b_d  = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (expire) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (!i_flash_busy) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // A real ack beats a simultaneous expiry.
                if (i_flash_ack) begin
                    done      = 1'b1;
                    done_data = i_flash_data;
                    state_d   = IDLE;
                end else if (expire) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            if (owner_b_q) begin
                b_ack_d  = 1'b1;
                b_data_d = done_data;
            end else begin
                a_ack_d  = 1'b1;
                a_data_d = done_data;
            end
        end
    end

    always_comb begin
        o_a_busy        = !((state_q == IDLE) && grant_a);
        o_b_busy        = !((state_q == IDLE) && grant_b);
        o_flash_request = (state_q == ISSUE);
        o_flash_address = addr_q;
        o_a_ack         = a_ack_q;
        o_b_ack         = b_ack_q;
        o_a_data        = a_data_q;
        o_b_data        = b_data_q;
    end

endmodule

// File: tb/tb_memory_flash_arbiter.sv
// Scoreboard bench for memory_flash_arbiter: directed transactions, queued expectations,
// a downstream flash responder and a per-port ack monitor.
module tb_memory_flash_arbiter;

    localparam int unsigned AW = 19;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, b_req;
    logic [AW-1:0] a_addr, b_addr;
    logic          a_busy, b_busy, a_ack, b_ack;
    logic [DW-1:0] a_data, b_data;
    logic          f_req, f_busy, f_ack;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_data;
    logic          timeout;
    logic          rsp_ack, stray_ack;
    logic [DW-1:0] rsp_data, stray_data;

    assign f_ack  = rsp_ack | stray_ack;
    assign f_data = stray_ack ? stray_data : rsp_data;

    always #5 clk = ~clk;

    memory_flash_arbiter #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_a_request    (a_req),
        .o_a_busy       (a_busy),
        .i_a_address    (a_addr),
        .o_a_ack        (a_ack),
        .o_a_data       (a_data),
        .i_b_request    (b_req),
        .o_b_busy       (b_busy),
        .i_b_address    (b_addr),
        .o_b_ack        (b_ack),
        .o_b_data       (b_data),
        .o_flash_request(f_req),
        .i_flash_busy   (f_busy),
        .o_flash_address(f_addr),
        .i_flash_ack    (f_ack),
        .i_flash_data   (f_data),
        .o_timeout      (timeout)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rsp_t;

    int unsigned   pass_cnt  = 0;
    int unsigned   total_cnt = 0;
    int unsigned   cyc       = 0;
    int unsigned   n_accept  = 0;
    int unsigned   a_ack_cyc = 0;
    int unsigned   b_ack_cyc = 0;
    int unsigned   rsp_delay = 0;
    bit            rsp_en    = 1'b1;
    logic [DW-1:0] exp_a[$];
    logic [DW-1:0] exp_b[$];
    rsp_t          rsp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every presented ack must match the head of that port's queue.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            if (a_ack && b_ack) check("dual_ack", {31'd0, a_ack & b_ack}, 32'd0);
            if (a_ack) begin
                a_ack_cyc = cyc;
                if (exp_a.size() == 0) check("a_unexpected_ack", {31'd0, a_ack}, 32'd0);
                else check("a_data", a_data, exp_a.pop_front());
            end
            if (b_ack) begin
                b_ack_cyc = cyc;
                if (exp_b.size() == 0) check("b_unexpected_ack", {31'd0, b_ack}, 32'd0);
                else check("b_data", b_data, exp_b.pop_front());
            end
        end
    end

    // Downstream flash model: serves accepted reads in the pre-planned order.
    initial begin
        rsp_t r;
        rsp_ack  = 1'b0;
        rsp_data = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && rsp_en && f_req && !f_busy) begin
                n_accept++;
                if (rsp_q.size() == 0) begin
                    check("flash_unexpected_req", {31'd0, f_req}, 32'd0);
                end else begin
                    r = rsp_q.pop_front();
                    check("flash_addr", {13'd0, f_addr}, {13'd0, r.addr});
                    @(posedge clk);
                    repeat (rsp_delay) @(posedge clk);
                    #1;
                    if (rst_n === 1'b1) begin
                        rsp_ack  = 1'b1;
                        rsp_data = r.data;
                        @(posedge clk);
                        #1 rsp_ack = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 100000", cyc);
        $fatal(1);
    end

    task automatic do_reset();
        rst_n  = 1'b0;
        a_req  = 1'b0;
        b_req  = 1'b0;
        exp_a.delete();
        exp_b.delete();
        rsp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic issue(input bit port_b, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [DW-1:0] exp, input bit to_flash, output int unsigned acc_cyc);
        bit acc = 1'b0;
        acc_cyc = 0;
        if (to_flash) rsp_q.push_back('{addr: addr, data: data});
        if (port_b) begin exp_b.push_back(exp); b_req = 1'b1; b_addr = addr; end
        else        begin exp_a.push_back(exp); a_req = 1'b1; a_addr = addr; end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (port_b ? !b_busy : !a_busy) begin
                acc     = 1'b1;
                acc_cyc = cyc;
                break;
            end
        end
        check("accept", {31'd0, acc}, 32'd1);
        @(posedge clk);
        #1;
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_a.size() == 0 && exp_b.size() == 0 && rsp_q.size() == 0 && !rsp_ack) break;
        end
        check("drain", exp_a.size() + exp_b.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned t;
        int unsigned a_n, b_n;
        bit          acc_a, acc_b;
        int unsigned n0;

        a_addr     = '0;
        b_addr     = '0;
        f_busy     = 1'b0;
        stray_ack  = 1'b0;
        stray_data = '0;
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_a_busy", {31'd0, a_busy}, 32'd1);
        check("rst_b_busy", {31'd0, b_busy}, 32'd1);
        check("rst_acks", {30'd0, a_ack, b_ack}, 32'd0);
        check("rst_a_data", a_data, 32'd0);
        check("rst_b_data", b_data, 32'd0);
        check("rst_flash_req", {31'd0, f_req}, 32'd0);
        check("rst_flash_addr", {13'd0, f_addr}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        @(posedge clk);
        #1;

        // Single A read, minimum latency
        issue(1'b0, 19'h00010, 32'h1234_5678, 32'h1234_5678, 1'b1, t);
        wait_done();
        check("t1_latency", a_ack_cyc - t, 32'd3);
        check("t1_b_data", b_data, 32'd0);

        // Both ports continuously requesting from reset: A,B,A,B,...
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rsp_q.push_back('{addr: 19'h00100 + 19'(i), data: 32'hA000_0000 + 32'(i)});
            rsp_q.push_back('{addr: 19'h40200 + 19'(i), data: 32'hB000_0000 + 32'(i)});
            exp_a.push_back(32'hA000_0000 + 32'(i));
            exp_b.push_back(32'hB000_0000 + 32'(i));
        end
        a_n = 0; b_n = 0;
        a_addr = 19'h00100; b_addr = 19'h40200;
        a_req = 1'b1; b_req = 1'b1;
        for (int c = 0; c < 200 && (a_n < 4 || b_n < 4); c++) begin
            @(negedge clk);
            acc_a = a_req && !a_busy;
            acc_b = b_req && !b_busy;
            @(posedge clk);
            #1;
            if (acc_a) begin a_n++; a_addr = 19'h00100 + 19'(a_n); a_req = (a_n < 4); end
            if (acc_b) begin b_n++; b_addr = 19'h40200 + 19'(b_n); b_req = (b_n < 4); end
        end
        check("t2_grants", a_n + b_n, 32'd8);
        wait_done();

        // Downstream busy for 5 cycles while the request is held
        f_busy = 1'b1;
        n0 = n_accept;
        issue(1'b0, 19'h059FF, 32'h3333_0001, 32'h3333_0001, 1'b1, t);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_req_held", {31'd0, f_req}, 32'd1);
            check("t3_addr_held", {13'd0, f_addr}, 32'h0000_59FF);
        end
        @(posedge clk);
        #1 f_busy = 1'b0;
        wait_done();
        check("t3_accepts", n_accept - n0, 32'd1);

        // Stray ack while idle is ignored
        stray_ack  = 1'b1;
        stray_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 stray_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_no_ack", {30'd0, a_ack, b_ack}, 32'd0);
            check("t4_a_data", a_data, 32'h3333_0001);
            check("t4_b_data", b_data, 32'hB000_0003);
        end
        @(posedge clk);
        #1;

        // Reset during WAIT_ACK aborts the read
        rsp_delay = 10;
        issue(1'b0, 19'h00777, 32'h5555_5555, 32'h5555_5555, 1'b1, t);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_a_ack", {31'd0, a_ack}, 32'd0);
        check("t5_a_data", a_data, 32'd0);
        check("t5_b_data", b_data, 32'd0);
        check("t5_flash_req", {31'd0, f_req}, 32'd0);
        check("t5_flash_addr", {13'd0, f_addr}, 32'd0);
        check("t5_a_busy", {31'd0, a_busy}, 32'd1);
        exp_a.delete();
        rsp_q.delete();
        repeat (15) @(posedge clk);
        rsp_delay = 0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 19'h00778, 32'h6666_0001, 32'h6666_0001, 1'b1, t);
        wait_done();
        check("t5_latency", a_ack_cyc - t, 32'd3);

`ifdef FLASH_ARB_TIMEOUT_EN
        // No downstream ack: forced completion TO cycles after ISSUE entry
        rsp_en = 1'b0;
        issue(1'b0, 19'h01234, 32'h0, 32'hFFFF_FFFF, 1'b0, t);
        wait_done();
        check("t6_latency", a_ack_cyc - t, 32'(TO + 1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_timeout_sticky", {31'd0, timeout}, 32'd1);
        end
        rsp_en = 1'b1;
        do_reset();
        @(negedge clk);
        check("t6_timeout_cleared", {31'd0, timeout}, 32'd0);
`else
        @(negedge clk);
        check("timeout_tied_low", {31'd0, timeout}, 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
